// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states and the oversampling ratio,
// used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int OVERSAMPLE = 16;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: serialises one DBIT-wide word per request,
// LSB first, timed by an external 16x oversample strobe.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic [DBIT-1:0] din,
    output logic            tx_busy,
    output logic            tx_done_tick,
    output logic            tx
);

    localparam int S_W = $clog2(max_int(OVERSAMPLE, SB_TICK) + 1);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
    localparam logic [S_W-1:0] S_ONE       = S_W'(1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);
    localparam logic [N_W-1:0] N_ONE       = N_W'(1);

    uart_state_e     state_r, state_s;
    logic [S_W-1:0]  s_r, s_s;
    logic [N_W-1:0]  n_r, n_s;
    logic [DBIT-1:0] b_r, b_s;
    logic            tx_r, tx_s;
    logic            busy_r, busy_s;
    logic            done_r, done_s;

    // Frame sequencing: next state, counters, shift register and output levels.
    always_comb begin
        state_s = state_r;
        s_s     = s_r;
        n_s     = n_r;
        b_s     = b_r;
        done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (tx_start) begin
                    state_s = START;
                    s_s     = {S_W{1'b0}};
                    b_s     = din;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_r == S_BIT_LAST) begin
                        state_s = DATA;
                        s_s     = {S_W{1'b0}};
                        n_s     = {N_W{1'b0}};
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_r == S_BIT_LAST) begin
                        s_s = {S_W{1'b0}};
                        b_s = b_r >> 1;
                        if (n_r == N_LAST) begin
                            state_s = STOP;
                        end else begin
                            n_s = n_r + N_ONE;
                        end
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_r == S_STOP_LAST) begin
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        s_s = s_r + S_ONE;
                    end
                end else begin
                    s_s = s_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Line level follows the state being entered so tx can come straight from a flop.
        case (state_s)
            IDLE:    tx_s = 1'b1;
            START:   tx_s = 1'b0;
            DATA:    tx_s = b_s[0];
            STOP:    tx_s = 1'b1;
            default: tx_s = 1'b1;
        endcase

        busy_s = (state_s != IDLE);
    end

    // State and output registers; reset returns the line to idle high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            s_r     <= {S_W{1'b0}};
            n_r     <= {N_W{1'b0}};
            b_r     <= {DBIT{1'b0}};
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            s_r     <= s_s;
            n_r     <= n_s;
            b_r     <= b_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign tx_done_tick = done_r;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven frame captures, hand-written
// corner sequences and a randomized run against a tick-counting line model.
module tb_uart_tx;

    localparam int DBIT        = 8;
    localparam int SB_TICK     = 16;
    localparam int FRAME_TICKS = (1 + DBIT) * 16 + SB_TICK;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       s_tick   = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] din      = 8'h00;
    logic       tx_busy;
    logic       tx_done_tick;
    logic       tx;

    uart_tx #(.DBIT(DBIT), .SB_TICK(SB_TICK)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .s_tick(s_tick),
        .tx_start(tx_start),
        .din(din),
        .tx_busy(tx_busy),
        .tx_done_tick(tx_done_tick),
        .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        int         div;
        logic [9:0] bits;   // expected line level at mid-bit, index 0 = start bit
    } vec_t;

    int         checks    = 0;
    int         errors    = 0;
    int         tick_div  = 4;
    int         div_cnt   = 0;
    bit         rand_tick = 1'b0;
    bit         m_busy    = 1'b0;
    bit         m_done    = 1'b0;
    int         m_k       = 0;
    logic [7:0] m_byte    = 8'h00;
    int         done_cnt  = 0;

    // Line level k ticks after accept: bit period k/16, start bit first, then data LSB first.
    function automatic logic line_level(input int k, input logic [7:0] byt);
        int bitp;
        bitp = k / 16;
        if (bitp == 0) return 1'b0;
        if (bitp <= DBIT) return byt[bitp-1];
        return 1'b1;
    endfunction

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive s_tick, advance the reference model, compare all outputs.
    task automatic cyc();
        logic e_tx;
        if (rand_tick) begin
            s_tick = ($urandom_range(0, 3) == 0);
        end else begin
            s_tick  = (div_cnt == tick_div - 1);
            div_cnt = (div_cnt + 1) % tick_div;
        end
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0; m_done = 1'b0; m_k = 0;
        end else if (!m_busy) begin
            m_done = 1'b0;
            if (tx_start) begin
                m_busy = 1'b1; m_k = 0; m_byte = din;
            end
        end else begin
            m_done = 1'b0;
            if (s_tick) begin
                m_k++;
                if (m_k == FRAME_TICKS) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end
        #1;
        e_tx = m_busy ? line_level(m_k, m_byte) : 1'b1;
        check1("model_tx", tx, e_tx);
        check1("model_busy", tx_busy, m_busy);
        check1("model_done", tx_done_tick, m_done);
        if (tx_done_tick) done_cnt++;
    endtask

    // Send one word and sample the line mid-bit; optionally re-request mid-frame with 8'hFF.
    task automatic send_capture(input logic [7:0] d, input int inject_tk,
                                output logic [9:0] bits, output int done_tk);
        int tk;
        int n;
        bit seen;
        tk = 0; n = 0; seen = 1'b0;
        bits = 10'h000; done_tk = -1;
        din = d; tx_start = 1'b1;
        cyc();
        tx_start = 1'b0;
        din = 8'($urandom);
        while (!seen && n < 20000) begin
            if (inject_tk >= 0 && tk == inject_tk) begin
                tx_start = 1'b1; din = 8'hFF;
            end else begin
                tx_start = 1'b0;
            end
            cyc();
            n++;
            if (s_tick) begin
                tk++;
                if (tk % 16 == 8 && tk / 16 < 10) bits[tk/16] = tx;
            end
            if (tx_done_tick) begin
                seen = 1'b1; done_tk = tk;
            end
        end
        tx_start = 1'b0;
    endtask

    initial begin
        vec_t       vecs[7];
        logic [9:0] bits;
        int         dtk;
        int         d0;
        int         tk;
        int         n;

        vecs[0] = '{8'hA5, 4, 10'h34A};
        vecs[1] = '{8'h00, 1, 10'h200};
        vecs[2] = '{8'hFF, 3, 10'h3FE};
        vecs[3] = '{8'h3C, 2, 10'h278};
        vecs[4] = '{8'h5A, 4, 10'h2B4};
        vecs[5] = '{8'h01, 1, 10'h202};
        vecs[6] = '{8'h80, 5, 10'h300};

        // Reset held: start requests must not begin a frame.
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tx_start = (i % 2 == 0);
            din = 8'hA5;
            cyc();
            check1("rst_tx", tx, 1'b1);
            check1("rst_busy", tx_busy, 1'b0);
        end
        check_int("rst_no_done", done_cnt, 0);
        tx_start = 1'b0;
        rst_n = 1'b1;
        repeat (4) cyc();
        check1("post_rst_tx", tx, 1'b1);

        for (int i = 0; i < 7; i++) begin
            tick_div = vecs[i].div;
            div_cnt  = 0;
            d0 = done_cnt;
            send_capture(vecs[i].din, -1, bits, dtk);
            checks++;
            if (bits !== vecs[i].bits) begin
                errors++;
                $display("FAIL vec%0d_bits: got %h expected %h", i, bits, vecs[i].bits);
            end
            check_int("vec_frame_ticks", dtk, FRAME_TICKS);
            check_int("vec_one_done", done_cnt - d0, 1);
            repeat (3) cyc();
        end

        // Re-request during DATA is ignored and nothing is queued.
        tick_div = 4; div_cnt = 0;
        d0 = done_cnt;
        send_capture(8'hA5, 16 + 3 * 16 + 2, bits, dtk);
        checks++;
        if (bits !== 10'h34A) begin
            errors++;
            $display("FAIL ignore_bits: got %h expected %h", bits, 10'h34A);
        end
        check_int("ignore_ticks", dtk, FRAME_TICKS);
        repeat (40) cyc();
        check_int("ignore_one_done", done_cnt - d0, 1);
        check1("ignore_idle_busy", tx_busy, 1'b0);

        // Back-to-back: start held, new word presented on the done cycle.
        d0 = done_cnt;
        din = 8'h00; tx_start = 1'b1;
        cyc();
        n = 0;
        while (!tx_done_tick && n < 5000) begin
            cyc(); n++;
        end
        check1("b2b_first_done", tx_done_tick, 1'b1);
        din = 8'hFF;
        cyc();
        tx_start = 1'b0;
        check1("b2b_no_gap", tx, 1'b0);
        tk = 0; n = 0;
        while (!tx_done_tick && n < 5000) begin
            cyc(); n++;
            if (s_tick) tk++;
        end
        check_int("b2b_spacing", tk, FRAME_TICKS);
        check_int("b2b_two_done", done_cnt - d0, 2);

        // Asynchronous abort in data bit 3, then a clean frame.
        repeat (5) cyc();
        din = 8'h33; tx_start = 1'b1;
        cyc();
        tx_start = 1'b0;
        tk = 0; n = 0;
        while (tk < 16 + 3 * 16 + 5 && n < 5000) begin
            cyc(); n++;
            if (s_tick) tk++;
        end
        check1("abort_pre_low", tx, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check1("abort_tx_async", tx, 1'b1);
        check1("abort_busy_async", tx_busy, 1'b0);
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        send_capture(8'h5A, -1, bits, dtk);
        checks++;
        if (bits !== 10'h2B4) begin
            errors++;
            $display("FAIL abort_next_bits: got %h expected %h", bits, 10'h2B4);
        end
        check_int("abort_next_ticks", dtk, FRAME_TICKS);

        // Randomized ticks, words, gaps and stray requests against the model.
        rand_tick = 1'b1;
        for (int f = 0; f < 30; f++) begin
            tx_start = 1'b0;
            repeat ($urandom_range(0, 5)) cyc();
            d0 = done_cnt;
            din = 8'($urandom); tx_start = 1'b1;
            cyc();
            n = 0;
            while (m_busy && n < 4000) begin
                tx_start = ($urandom_range(0, 40) == 0);
                din = 8'($urandom);
                cyc(); n++;
            end
            tx_start = 1'b0;
            check_int("rand_one_done", done_cnt - d0, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1-style UART transmitter, same oversampled tick scheme as the receive path: one bit period = 16 s_tick pulses. A shared counter instance generates s_tick, with VALUE_MAX 54 for 115200 baud at 100 MHz.
- Serialises one byte per request onto tx. It is the stage that drives the serial line consumed by the receive path; used standalone for echo/loopback and as the bench stimulus source for the receiver.

Parameters:
- DBIT, 8, number of data bits per frame, sent LSB first.
- SB_TICK, 16, stop-bit length in s_tick pulses (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- s_tick  input  1  single-cycle oversample strobe, 16 per bit period.
- tx_start  input  1  request to send din; sampled every clk.
- din  input  DBIT  byte to transmit; captured on accept.
- tx_busy  output  1  high from the cycle after accept until the cycle tx_done_tick is asserted.
- tx_done_tick  output  1  one-clk pulse at the end of the stop bit.
- tx  output  1  serial line, idle high, registered.

Behaviour:
- Reset, asynchronous while rst_n low:
  - tx=1, tx_busy=0, tx_done_tick=0.
  - state=IDLE, tick count s=0, bit count n=0, shift register b=0.
  - Reset mid-frame aborts the frame immediately and returns the line high.
- Accept: in IDLE, tx_start=1 on a clk edge:
  - b<=din, s<=0, state<=START.
  - tx=0 and tx_busy=1 from the next cycle.
  - tx_start while not IDLE is ignored; no queueing.
- The tick counter s advances only on cycles with s_tick=1. A clk with s_tick=0 holds all state.
- START: tx=0. On s_tick with s==15: s<=0, n<=0, state<=DATA. Otherwise, on s_tick, s<=s+1.
- DATA: tx=b[0]. On s_tick with s==15:
  - s<=0, b<=b>>1.
  - If n==DBIT-1, state<=STOP; else n<=n+1.
- STOP: tx=1. On s_tick with s==SB_TICK-1:
  - state<=IDLE, tx_done_tick=1 for exactly that next cycle, tx_busy=0 from that same cycle.
- Back-to-back: tx_start may be asserted in the cycle tx_done_tick is high and is accepted, because the state is already IDLE. The line stays high for 0 extra ticks between frames.
- Frame duration: exactly (1+DBIT)*16 + SB_TICK s_tick pulses from accept to the done pulse. The first bit period starts on the accept edge, so the start bit may be up to one tick period shorter when s_tick is free-running. This is acceptable at 16x oversampling.
- tx is driven from a flop, never combinationally from state, so the line is glitch-free.
- s_tick asserted in the same cycle as the accept is not counted toward the start bit.
- din changes after accept have no effect on the frame in flight.
- Widths:
  - s is wide enough for max(16, SB_TICK); 5 bits for the defaults.
  - n is $clog2(DBIT) bits.

Decomposition:
- Shared package uart_pkg holds:
  - enum uart_state_e {IDLE, START, DATA, STOP}, reused by the receive FSM.
  - constant OVERSAMPLE=16.
- No sub-module; the tick source is the existing counter, instantiated by the parent top.

Test Plan:
- Reset: hold rst_n=0, pulse tx_start -> tx=1, tx_busy=0, no done pulse; release -> tx stays 1.
- Single frame: s_tick every 4 clk, din=8'hA5, tx_start for 1 cycle -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each level lasting 64 clk (±4 on the start bit). Exactly one tx_done_tick after 160 ticks; tx_busy low after that.
- Ignore while busy: second tx_start with din=8'hFF mid-DATA -> frame still carries 8'hA5, only one done pulse.
- Back-to-back: tx_start held high with din 8'h00 then 8'hFF, switched on the done cycle -> two contiguous frames, no idle gap, two done pulses 160 ticks apart.
- Loopback: tx wired to the receive path (uart_rx + uart_rx_buffer), send 8'h3C -> receiver dout=8'h3C, one rx_done_tick; repeat for all 256 values.
- Abort: assert rst_n=0 during DATA bit 3 -> tx=1 immediately (asynchronous). After release, a new frame for 8'h5A is transmitted correctly.
